out_quant_pack: RTL and testbench

OUT_QUANT_PACK -- requirements
Module: out_quant_pack

---
 rtl/out_pack_pkg.sv | 15 +
 rtl/out_word_fifo.sv | 77 +++++++
 rtl/out_quant_pack.sv | 146 ++++++++++++++
 tb/tb_out_quant_pack.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_pack_pkg.sv
// Shared sizing and the output word entry layout for the quantize/pack output stage.
package out_pack_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned Q_W        = 8;
  localparam int unsigned LANES      = 4;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [LANES-1:0]  byte_en;
    logic              last;
  } out_word_t;

endpackage

// File: rtl/out_word_fifo.sv
// First-word-fall-through word FIFO with synchronous flush and occupancy output.
module out_word_fifo
  import out_pack_pkg::*;
#(
  parameter int unsigned Depth = FIFO_DEPTH,
  parameter int unsigned Width = $bits(out_word_t),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] rd_data_o,
  output logic             valid_o,
  output logic [CntW-1:0]  occupancy_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             full, push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full        = (cnt_q == CntW'(Depth));
  assign valid_o     = (cnt_q != '0);
  assign pop_ok      = pop_i & valid_o;
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign push_ok     = push_i & (~full | pop_ok);
  assign rd_data_o   = mem_q[rd_ptr_q];
  assign occupancy_o = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (push_ok && !flush_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/out_quant_pack.sv
// Requantizes ReLU'd partial sums to bytes, packs them into words per row, and buffers the
// words in a small FWFT FIFO with occupancy-based back-pressure.
module out_quant_pack #(
  parameter int unsigned DATA_W     = out_pack_pkg::DATA_W,
  parameter int unsigned Q_W        = out_pack_pkg::Q_W,
  parameter int unsigned FIFO_DEPTH = out_pack_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        cfg_shift,
  input  logic [7:0]        cfg_row_len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              stall_req,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_byte_en,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned Lanes  = out_pack_pkg::LANES;
  localparam int unsigned LaneW  = $clog2(Lanes);
  localparam int unsigned SumW   = DATA_W + 1;
  localparam int unsigned EntryW = DATA_W + Lanes + 1;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);

  logic                accept;
  logic [SumW-1:0]     round_add, sum_w, shifted_w;
  logic [Q_W-1:0]      q_w;
  logic                s1_valid_q, s1_valid_d;
  logic [Q_W-1:0]      s1_q_q, s1_q_d;
  logic [DATA_W-1:0]   pk_data_q, pk_data_d, merged_data;
  logic [Lanes-1:0]    pk_be_q, pk_be_d, merged_be;
  logic [7:0]          elem_q, elem_d, last_idx;
  logic [LaneW-1:0]    lane;
  logic                elem_last;
  logic                wr_valid_q, wr_valid_d, wr_last_q, wr_last_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [Lanes-1:0]    wr_be_q, wr_be_d;
  logic [EntryW-1:0]   head;
  logic [CntW-1:0]     occupancy;
  logic                fifo_valid;

  assign accept = in_valid & ~stall_req & ~start;

  // Round-half-up shift in DATA_W+1 bits so the rounding add cannot overflow.
  always_comb begin
    round_add = '0;
    if (cfg_shift != 5'd0) round_add = SumW'(1) << (cfg_shift - 5'd1);
    sum_w     = {1'b0, in_data} + round_add;
    shifted_w = sum_w >> cfg_shift;
    if (in_data[DATA_W-1])                           q_w = '0;
    else if (shifted_w > SumW'((1 << Q_W) - 1))      q_w = '1;
    else                                             q_w = shifted_w[Q_W-1:0];
  end

  always_comb begin
    s1_valid_d = accept;
    s1_q_d     = accept ? q_w : s1_q_q;
  end

  // Row length 0 wraps to 255 here, which is exactly the last index of a 256-element row.
  assign last_idx  = cfg_row_len - 8'd1;
  assign elem_last = (elem_q == last_idx);
  assign lane      = elem_q[LaneW-1:0];

  always_comb begin
    merged_data = pk_data_q;
    merged_data[lane*Q_W +: Q_W] = s1_q_q;
    merged_be   = pk_be_q | (Lanes'(1) << lane);
    pk_data_d   = pk_data_q;
    pk_be_d     = pk_be_q;
    elem_d      = elem_q;
    wr_valid_d  = 1'b0;
    wr_data_d   = wr_data_q;
    wr_be_d     = wr_be_q;
    wr_last_d   = wr_last_q;
    if (start) begin
      pk_data_d = '0;
      pk_be_d   = '0;
      elem_d    = '0;
    end else if (s1_valid_q) begin
      if (lane == LaneW'(Lanes - 1) || elem_last) begin
        wr_valid_d = 1'b1;
        wr_data_d  = merged_data;
        wr_be_d    = merged_be;
        wr_last_d  = elem_last;
        pk_data_d  = '0;
        pk_be_d    = '0;
      end else begin
        pk_data_d = merged_data;
        pk_be_d   = merged_be;
      end
      elem_d = elem_last ? 8'd0 : elem_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q_q     <= '0;
      pk_data_q  <= '0;
      pk_be_q    <= '0;
      elem_q     <= '0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
      wr_be_q    <= '0;
      wr_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q_q     <= s1_q_d;
      pk_data_q  <= pk_data_d;
      pk_be_q    <= pk_be_d;
      elem_q     <= elem_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      wr_be_q    <= wr_be_d;
      wr_last_q  <= wr_last_d;
    end
  end

  out_word_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (start),
    .push_i      (wr_valid_q),
    .wr_data_i   ({wr_data_q, wr_be_q, wr_last_q}),
    .pop_i       (out_ready),
    .rd_data_o   (head),
    .valid_o     (fifo_valid),
    .occupancy_o (occupancy)
  );

  // Two slots of headroom cover the byte in stage 1 and the word waiting to be pushed.
  assign stall_req   = (32'(occupancy) + 32'd2 >= FIFO_DEPTH);
  assign out_valid   = fifo_valid;
  assign out_data    = fifo_valid ? head[EntryW-1 -: DATA_W] : '0;
  assign out_byte_en = fifo_valid ? head[Lanes:1] : '0;
  assign out_last    = fifo_valid & head[0];

endmodule

// File: tb/tb_out_quant_pack.sv
// Scoreboard bench for out_quant_pack: directed cases plus randomized rows checked against
// an arithmetic reference model.
module tb_out_quant_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  cfg_shift = '0;
  logic [7:0]  cfg_row_len = 8'd4;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        stall_req;
  logic [31:0] out_data;
  logic [3:0]  out_byte_en;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  be;
    logic        l;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  m_bytes[$];
  int          m_pos = 0;
  int          total = 0;
  int          bad = 0;
  int          ready_mode = 0;
  bit          use_model = 1'b0;

  out_quant_pack dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_shift   (cfg_shift),
    .cfg_row_len (cfg_row_len),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .stall_req   (stall_req),
    .out_data    (out_data),
    .out_byte_en (out_byte_en),
    .out_last    (out_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic void exp_push(logic [31:0] d, logic [3:0] be, logic l);
    exp_t e;
    e.d = d; e.be = be; e.l = l;
    exp_q.push_back(e);
  endfunction

  function automatic int row_len_int();
    return (cfg_row_len == 8'd0) ? 256 : int'(cfg_row_len);
  endfunction

  // Reference: quantize with plain integer arithmetic, collect bytes until the row ends or
  // four bytes are gathered.
  function automatic void model_in(logic [31:0] d);
    longint v;
    int     q;
    int     rl;
    logic [31:0] w;
    rl = row_len_int();
    if ($signed(d) < 0) q = 0;
    else begin
      v = longint'(d);
      if (cfg_shift > 0) v = v + (longint'(1) << (cfg_shift - 1));
      v = v >> cfg_shift;
      q = (v > 255) ? 255 : int'(v);
    end
    m_bytes.push_back(q[7:0]);
    if (m_bytes.size() == 4 || m_pos == rl - 1) begin
      w = '0;
      for (int i = 0; i < m_bytes.size(); i++) w[8*i +: 8] = m_bytes[i];
      exp_push(w, 4'((1 << m_bytes.size()) - 1), m_pos == rl - 1);
      m_bytes.delete();
    end
    m_pos = (m_pos == rl - 1) ? 0 : m_pos + 1;
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    m_bytes.delete();
    m_pos = 0;
  endfunction

  // Monitor: drives out_ready and checks each handshaken word against the scoreboard.
  initial begin
    exp_t e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (ready_mode == 0)      out_ready = 1'b0;
      else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
      else                      out_ready = 1'b1;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mon_unexpected: got word %0h be %0h, want no word", out_data,
                   out_byte_en);
        end else begin
          e = exp_q.pop_front();
          chk("mon_data", 64'(out_data), 64'(e.d));
          chk("mon_be", 64'(out_byte_en), 64'(e.be));
          chk("mon_last", 64'(out_last), 64'(e.l));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] d);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (stall_req && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      chk("send_timeout", 64'(stall_req), 64'd0);
    end else begin
      if (use_model) model_in(d);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    repeat (2) @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = $urandom;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    chk("start_flush", 64'(out_valid), 64'd0);
  endtask

  task automatic wait_drain();
    int guard = 0;
    ready_mode = 2;
    while ((exp_q.size() != 0) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge clk);
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("drain_stall", 64'(stall_req), 64'd0);
  endtask

  task automatic set_cfg(input logic [4:0] sh, input logic [7:0] rl);
    ready_mode  = 0;
    cfg_shift   = sh;
    cfg_row_len = rl;
    do_start();
  endtask

  initial begin
    int acc;
    logic [31:0] d;
    #3;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_be", 64'(out_byte_en), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Worked example with latency check.
    set_cfg(5'd4, 8'd4);
    send(32'd16); send(32'd17); send(32'd24); send(-32'sd5);
    chk("lat_n", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_n1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_n2", 64'(out_valid), 64'd1);
    chk("lat_word", 64'(out_data), 64'h00020101);
    exp_push(32'h00020101, 4'hF, 1'b1);
    wait_drain();

    // Saturation, rounding, negative clamp; single-element rows.
    set_cfg(5'd0, 8'd1);
    send(32'd300);
    exp_push(32'h000000FF, 4'h1, 1'b1);
    wait_drain();
    set_cfg(5'd1, 8'd1);
    send(32'd3); send(32'd2); send(-32'sd1);
    exp_push(32'h02, 4'h1, 1'b1);
    exp_push(32'h01, 4'h1, 1'b1);
    exp_push(32'h00, 4'h1, 1'b1);
    wait_drain();

    // Six-element row splits into a full word and a two-byte last word.
    set_cfg(5'd0, 8'd6);
    for (int i = 1; i <= 6; i++) send(32'(i));
    exp_push(32'h04030201, 4'hF, 1'b0);
    exp_push(32'h00000605, 4'h3, 1'b1);
    wait_drain();

    // Back-pressure with the consumer blocked.
    set_cfg(5'd0, 8'd1);
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i + 1);
      if (!stall_req) begin
        acc++;
        exp_push(32'(i + 1), 4'h1, 1'b1);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd4);
    chk("bp_stall", 64'(stall_req), 64'd1);
    chk("bp_valid", 64'(out_valid), 64'd1);
    wait_drain();

    // Start mid-row discards the partial row.
    set_cfg(5'd0, 8'd4);
    send(32'd7); send(32'd8);
    do_start();
    send(32'd11); send(32'd22); send(32'd33); send(32'd44);
    exp_push(32'h2C21160B, 4'hF, 1'b1);
    wait_drain();

    // Reset mid-row with two words queued.
    set_cfg(5'd0, 8'd4);
    for (int i = 0; i < 10; i++) send(32'(i + 1));
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    chk("mid_rst_be", 64'(out_byte_en), 64'd0);
    chk("mid_rst_stall", 64'(stall_req), 64'd0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    ready_mode = 1;
    send(32'd5); send(32'd6); send(32'd7); send(32'd8);
    exp_push(32'h08070605, 4'hF, 1'b1);
    wait_drain();

    // Randomized rows against the reference model.
    use_model = 1'b1;
    for (int c = 0; c < 6; c++) begin
      set_cfg(5'($urandom_range(0, 12)), 8'($urandom_range(1, 9)));
      ready_mode = 1;
      for (int n = 0; n < 40; n++) begin
        case ($urandom_range(0, 3))
          0:       d = 32'($urandom_range(0, 600));
          1:       d = -32'($urandom_range(1, 1000));
          2:       d = $urandom;
          default: d = 32'($urandom_range(0, 70000));
        endcase
        send(d);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      wait_drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
